bm_uniform_packer: RTL and testbench



---
 rtl/bm_uniform_packer.sv | 87 ++++++++
 tb/tb_bm_uniform_packer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/bm_uniform_packer.sv
// Pairs 32-bit Tausworthe words into (u0, u1) uniforms for the Box-Muller datapath,
// rejects u0 == 0 pairs and buffers accepted pairs in a 2-entry valid/ready FIFO.
module bm_uniform_packer #(
  parameter int DROP_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           y,
  input  logic                  y_valid,
  output logic                  y_ready,
  output logic [47:0]           u0,
  output logic [15:0]           u1,
  output logic                  uv_valid,
  input  logic                  uv_ready,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  typedef enum logic {EMPTY, HALF} state_t;

  state_t      state, state_next;
  logic [31:0] w0;
  logic [63:0] mem [2];
  logic        rd_ptr, wr_ptr;
  logic [1:0]  count;
  logic        word_xfer, load_w0, pair_done, push, pop, drop;
  logic [47:0] pair_u0;

  // y_ready depends only on registered occupancy, never on uv_ready
  assign y_ready   = !reset && (count < 2'd2);
  assign word_xfer = y_valid && y_ready;
  assign pair_u0   = {w0, y[31:16]};
  assign uv_valid  = (count != 2'd0);
  assign pop       = uv_valid && uv_ready;
  assign {u0, u1}  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) state <= EMPTY;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (word_xfer) state_next = HALF;
      HALF:    if (word_xfer) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  always_comb begin
    load_w0   = 1'b0;
    pair_done = 1'b0;
    if (word_xfer) begin
      load_w0   = (state == EMPTY);
      pair_done = (state == HALF);
    end
    push = pair_done && (pair_u0 != 48'h0);
    drop = pair_done && (pair_u0 == 48'h0);
  end

  // A push at count 2 cannot happen since y_ready is low there
  always_ff @(posedge clk) begin
    if (reset) begin
      w0       <= '0;
      mem[0]   <= '0;
      mem[1]   <= '0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      count    <= 2'd0;
      drop_cnt <= '0;
    end else begin
      if (load_w0) w0 <= y;
      if (push) begin
        mem[wr_ptr] <= {pair_u0, y[15:0]};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (drop && (drop_cnt != {DROP_CNT_W{1'b1}})) drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_bm_uniform_packer.sv
// Randomized and directed scoreboard bench for bm_uniform_packer; a word-level
// reference model forms expected pairs, a monitor compares every FIFO head.
module tb_bm_uniform_packer;

  localparam int DW      = 2;
  localparam int DROPMAX = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   y = '0;
  logic          y_valid = 1'b0;
  logic          y_ready;
  logic [47:0]   u0;
  logic [15:0]   u1;
  logic          uv_valid;
  logic          uv_ready = 1'b0;
  logic [DW-1:0] drop_cnt;

  int asserts  = 0;
  int failures = 0;
  bit rand_mode = 1'b0;

  logic [63:0] sb[$];
  bit          have_w0 = 1'b0;
  logic [31:0] mw0 = '0;
  int          mdrop = 0;

  bm_uniform_packer #(.DROP_CNT_W(DW)) dut (
    .clk(clk), .reset(reset), .y(y), .y_valid(y_valid), .y_ready(y_ready),
    .u0(u0), .u1(u1), .uv_valid(uv_valid), .uv_ready(uv_ready), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    asserts++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: accepted words are consumed two at a time by the pairing rule
  always @(negedge clk) begin
    logic [47:0] pu0;
    #3;
    if (reset) begin
      sb.delete();
      have_w0 = 1'b0;
      mdrop   = 0;
    end else if (y_valid && y_ready) begin
      if (!have_w0) begin
        mw0     = y;
        have_w0 = 1'b1;
      end else begin
        pu0     = {mw0, y[31:16]};
        have_w0 = 1'b0;
        if (pu0 == 48'h0) begin
          if (mdrop < DROPMAX) mdrop++;
        end else begin
          sb.push_back({pu0, y[15:0]});
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      checkOutput("y_ready_in_reset", {63'h0, y_ready}, 64'h0);
    end else begin
      checkOutput("y_ready", {63'h0, y_ready}, {63'h0, sb.size() < 2});
      checkOutput("uv_valid", {63'h0, uv_valid}, {63'h0, sb.size() != 0});
      checkOutput("drop_cnt", 64'(drop_cnt), 64'(mdrop));
      if (uv_valid && sb.size() != 0) begin
        checkOutput("head", {u0, u1}, sb[0]);
        if (uv_ready) void'(sb.pop_front());
      end
    end
  end

  // Called and returns at posedge+1; holds the word until the block takes it
  task automatic applyStimulus(input logic [31:0] w);
    int  waited = 0;
    bit  taken  = 1'b0;
    y       = w;
    y_valid = 1'b1;
    while (!taken) begin
      @(negedge clk);
      taken = y_ready;
      @(posedge clk); #1;
      if (rand_mode) uv_ready = 1'($urandom_range(0, 1));
      waited++;
      if (!taken && waited > 100) begin
        checkOutput("word_accept_timeout", 64'h0, 64'h1);
        taken = 1'b1;
      end
    end
    y_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      if (rand_mode) uv_ready = 1'($urandom_range(0, 1));
    end
  endtask

  int          drop_exp [5] = '{1, 2, 3, 3, 3};
  logic [15:0] u1_before;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_uv_valid", {63'h0, uv_valid}, 64'h0);
    checkOutput("reset_u0", 64'(u0), 64'h0);
    checkOutput("reset_u1", 64'(u1), 64'h0);
    checkOutput("reset_drop_cnt", 64'(drop_cnt), 64'h0);
    @(posedge clk); #1;
    reset    = 1'b0;
    uv_ready = 1'b1;

    applyStimulus(32'h00000001);
    applyStimulus(32'h23456789);
    @(negedge clk);
    checkOutput("first_pair_valid", {63'h0, uv_valid}, 64'h1);
    checkOutput("first_pair_u0", 64'(u0), 64'h000000012345);
    checkOutput("first_pair_u1", 64'(u1), 64'h6789);
    @(negedge clk);
    checkOutput("first_pair_one_cycle", {63'h0, uv_valid}, 64'h0);
    u1_before = u1;
    @(posedge clk); #1;

    applyStimulus(32'h00000000);
    applyStimulus(32'h0000ABCD);
    @(negedge clk);
    checkOutput("reject_no_valid", {63'h0, uv_valid}, 64'h0);
    checkOutput("reject_drop_cnt", 64'(drop_cnt), 64'h1);
    checkOutput("reject_u1_held", 64'(u1), 64'(u1_before));
    @(posedge clk); #1;
    applyStimulus(32'h00000000);
    applyStimulus(32'h00010000);
    @(negedge clk);
    checkOutput("small_u0_valid", {63'h0, uv_valid}, 64'h1);
    checkOutput("small_u0", 64'(u0), 64'h000000000001);
    checkOutput("small_u1", 64'(u1), 64'h0);
    @(posedge clk); #1;

    uv_ready = 1'b0;
    applyStimulus(32'hA1A1A1A1);
    applyStimulus(32'hB2B2C3C3);
    applyStimulus(32'h33334444);
    applyStimulus(32'h55556666);
    idle(2);
    @(negedge clk);
    checkOutput("bp_y_ready_low", {63'h0, y_ready}, 64'h0);
    checkOutput("bp_head_u0", 64'(u0), 64'h0000A1A1A1A1B2B2);
    checkOutput("bp_head_u1", 64'(u1), 64'hC3C3);
    @(posedge clk); #1;
    uv_ready = 1'b1;
    applyStimulus(32'h77778888);
    applyStimulus(32'h9999AAAA);
    idle(4);

    uv_ready = 1'b0;
    applyStimulus(32'h0BADF00D);
    applyStimulus(32'h11112222);
    applyStimulus(32'hCAFEBABE);
    uv_ready = 1'b1;
    applyStimulus(32'hDEAD5A5A);
    @(negedge clk);
    checkOutput("pushpop_valid", {63'h0, uv_valid}, 64'h1);
    checkOutput("pushpop_u0", 64'(u0), 64'h0000CAFEBABEDEAD);
    checkOutput("pushpop_u1", 64'(u1), 64'h5A5A);
    idle(2);

    applyStimulus(32'hFFFFFFFF);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    applyStimulus(32'h00000002);
    applyStimulus(32'h00030004);
    @(negedge clk);
    checkOutput("midreset_valid", {63'h0, uv_valid}, 64'h1);
    checkOutput("midreset_u0", 64'(u0), 64'h000000020003);
    checkOutput("midreset_u1", 64'(u1), 64'h0004);
    idle(2);

    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(32'h00000000);
      applyStimulus(32'h0000FFFF);
      @(negedge clk);
      checkOutput("saturation_drop_cnt", 64'(drop_cnt), 64'(drop_exp[i]));
      @(posedge clk); #1;
    end

    rand_mode = 1'b1;
    for (int i = 0; i < 400; i++) begin
      logic [31:0] w;
      w = $urandom;
      if ($urandom_range(0, 3) == 0) w[31:16] = 16'h0;
      if ($urandom_range(0, 7) == 0) w = 32'h0;
      applyStimulus(w);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    rand_mode = 1'b0;
    uv_ready  = 1'b1;
    idle(6);
    @(negedge clk);
    checkOutput("drained", 64'(sb.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
